// File: rtl/c7bbiu_axi_rd_slv.sv
// AXI4 read-channel responder fetching doublewords from a synchronous SRAM port.
// Optional random FETCH stalls when C7B_AXI_RD_SLV_STALL_EN is defined.
module c7bbiu_axi_rd_slv #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [3:0]        ar_id,
  input  logic [31:0]       ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [3:0]        r_id,
  output logic [63:0]       r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [63:0]       mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_e;

  state_e            state_q;
  logic              ar_ready_q;
  logic [3:0]        id_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [28:0]       addr_q;
  logic              slverr_q;
  logic              fixed_q;
  logic              r_valid_q;
  logic [3:0]        r_id_q;
  logic [63:0]       r_data_q;
  logic [1:0]        r_resp_q;
  logic              r_last_q;
  logic              beat_ok_q;
  logic              data_fresh_q;
  logic              mem_rd_en_q;
  logic [MEM_AW-1:0] mem_rd_addr_q;

  logic              ar_fire;
  logic              bad_req_d;
  logic [28:0]       addr_d;
  logic              slverr_d;
  logic              ok_d;
  logic [1:0]        resp_d;
  logic              fetch_hold;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^ar_addr[2:0];

`ifdef C7B_AXI_RD_SLV_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign fetch_hold = lfsr_q[0];
`else
  assign fetch_hold = 1'b0;
`endif

  // Next-beat address/error: from the AR channel on acceptance, else stepped from the current beat.
  always_comb begin
    ar_fire   = (state_q == S_IDLE) & ar_valid & ar_ready_q;
    bad_req_d = (ar_size != 3'b011) | ar_burst[1];
    addr_d    = ar_fire ? ar_addr[31:3] : (fixed_q ? addr_q : addr_q + 29'd1);
    slverr_d  = ar_fire ? bad_req_d : slverr_q;
    ok_d      = ~slverr_d & ~(|addr_d[28:MEM_AW]);
    resp_d    = slverr_q ? 2'b10 : ((|addr_q[28:MEM_AW]) ? 2'b11 : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ar_ready_q    <= 1'b0;
      id_q          <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
      slverr_q      <= 1'b0;
      fixed_q       <= 1'b0;
      r_valid_q     <= 1'b0;
      r_id_q        <= '0;
      r_data_q      <= '0;
      r_resp_q      <= '0;
      r_last_q      <= 1'b0;
      beat_ok_q     <= 1'b0;
      data_fresh_q  <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      data_fresh_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_fire) begin
            ar_ready_q    <= 1'b0;
            id_q          <= ar_id;
            len_q         <= ar_len;
            beat_q        <= '0;
            slverr_q      <= bad_req_d;
            fixed_q       <= (ar_burst == 2'b00);
            addr_q        <= addr_d;
            mem_rd_en_q   <= ok_d;
            mem_rd_addr_q <= addr_d[MEM_AW-1:0];
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch_hold) begin
            mem_rd_en_q  <= 1'b0;
            r_valid_q    <= 1'b1;
            r_id_q       <= id_q;
            r_resp_q     <= resp_d;
            r_last_q     <= (beat_q == len_q);
            beat_ok_q    <= (resp_d == 2'b00);
            data_fresh_q <= 1'b1;
            r_data_q     <= '0;
            state_q      <= S_DATA;
          end
        end
        S_DATA: begin
          // SRAM data is only present in the first DATA cycle; capture it for the rest of the beat.
          if (data_fresh_q) r_data_q <= beat_ok_q ? mem_rd_data : 64'h0;
          if (r_ready) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            if (beat_q == len_q) begin
              ar_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              beat_q        <= beat_q + 8'd1;
              addr_q        <= addr_d;
              mem_rd_en_q   <= ok_d;
              mem_rd_addr_q <= addr_d[MEM_AW-1:0];
              state_q       <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ar_ready    = ar_ready_q;
  assign r_valid     = r_valid_q;
  assign r_id        = r_id_q;
  assign r_data      = (data_fresh_q & beat_ok_q) ? mem_rd_data : r_data_q;
  assign r_resp      = r_resp_q;
  assign r_last      = r_last_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;

endmodule
